fpadd_operand_sequencer: RTL and testbench
==========================================

# fpadd_operand_sequencer

Front-panel controller for the Zedboard FP adder. It takes single-cycle button pulses from the debounce stage and collects two 32-bit operands one byte at a time from the 8 slide switches. It then starts the adder, waits for its result with a watchdog, and shows the result byte by byte on the 8 LEDs. It sits between the button debouncers / switch inputs and the FP adder core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255 — maximum WAIT cycles before declaring an adder fault; must be ≥ 1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; synchronous, active-high.
- btn_enter  in  1  single-cycle pulse: accept byte / advance.
- btn_back  in  1  single-cycle pulse: step back / restart.
- sw  in  8  switch byte.
- op_a  out  32  operand A to adder, registered.
- op_b  out  32  operand B to adder, registered.
- add_start  out  1  one-cycle start pulse to adder.
- add_done  in  1  adder result-valid pulse.
- add_result  in  32  adder result; sampled only when add_done=1 in WAIT.
- led  out  8  front-panel display.
- busy  out  1  high while in WAIT.
- err  out  1  high while in ERR.

## Operation
- States: LOAD_A, LOAD_B, START, WAIT, SHOW, ERR.
- A 2-bit byte index `idx` is used; bytes go MSB first, starting at idx=3.
- Button decode: enter and back asserted in the same cycle are both ignored (no state, idx or data change).
- LOAD_A:
  - enter: op_a[8*idx +: 8] <= sw.
  - If idx>0: idx decrements. If idx==0: go to LOAD_B, idx=3.
  - back: if idx<3, idx increments (re-enter previous byte). At idx==3, back is ignored.
- LOAD_B:
  - enter: same byte load into op_b. At idx==0, go to START.
  - back: if idx<3, idx increments. At idx==3, go to LOAD_A with idx=0.
- START:
  - add_start=1 for exactly this cycle; clear the watchdog counter.
  - Unconditionally go to WAIT.
- WAIT:
  - add_done=1: result register <= add_result; go to SHOW, idx=3.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES, go to ERR.
  - add_done in the same cycle as the counter reaching TIMEOUT_CYCLES: done wins.
  - Buttons are ignored in WAIT.
- SHOW:
  - led = result[8*idx +: 8].
  - enter: idx decrements, wrapping 0→3.
  - back: go to LOAD_A, idx=3. op_a and op_b are retained; bytes are overwritten as they are re-entered.
- ERR:
  - enter or back (not both): go to LOAD_A, idx=3.
- add_done outside WAIT is ignored.
- led in non-SHOW states:
  - LOAD_A: {4'h1, onehot(idx)}.
  - LOAD_B: {4'h2, onehot(idx)}.
  - START/WAIT: 8'h40.
  - ERR: 8'hEE.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- All outputs are registered, or decoded from registered state only. No combinational path from inputs to outputs.
- Reset values: state=LOAD_A, idx=3, op_a=0, op_b=0, result=0, add_start=0, busy=0, err=0, led=8'h18.
- Reset mid-operation, including during WAIT, returns all state to the reset values on the next edge. A late add_done after reset is ignored.
- A byte loaded by enter on edge N is visible on op_a/op_b after edge N. The final op_b byte (idx 0) lands together with the transition to START.
- add_start is high in the cycle after the last enter and is always exactly one cycle wide. op_a and op_b are stable from that cycle until the next LOAD state.
- add_done sampled on edge M: SHOW, with led showing result[31:24], is visible after edge M.
- Timeout: with no add_done, ERR is entered on the edge where the counter hits TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 cycles after START.
- busy=1 exactly while in WAIT; err=1 exactly while in ERR.

## Configuration
- Macro FPSEQ_RESULT_CHAIN_EN.
- Defined: back in SHOW copies result into op_a and goes to LOAD_B with idx=3, so the result becomes the next operand A (accumulate chain).
- Undefined: back in SHOW goes to LOAD_A, idx=3, as described in Operation.

## Test plan
- Basic add, adder model with done 5 cycles after start:
  - Stimulus: reset; enter bytes 3F,80,00,00 for A and 40,00,00,00 for B. Model returns 40400000.
  - Response: op_a=3F800000, op_b=40000000; one add_start pulse; SHOW led sequence 40,40,00,00 over three enters, then wrap back to 40 on the fourth enter.
- Back-step correction:
  - Stimulus: in LOAD_A, enter AA, back, enter 3F.
  - Response: op_a[31:24]=3F, idx=2, led=8'h14.
  - Stimulus: back at LOAD_B idx 3.
  - Response: LOAD_A idx=0, led=8'h11.
- Watchdog, TIMEOUT_CYCLES=4, adder never responds:
  - Response: ERR after 5 cycles, err=1, led=EE, busy=0.
  - Stimulus: enter.
  - Response: LOAD_A idx=3.
- Simultaneous/ignored events:
  - Stimulus: enter+back in the same cycle in LOAD_A.
  - Response: no change.
  - Stimulus: add_done in LOAD_B.
  - Response: result unchanged.
  - Stimulus: add_done on the timeout cycle.
  - Response: SHOW, not ERR.
- Reset in WAIT:
  - Stimulus: assert rst for one cycle.
  - Response: all reset values; a later add_done is ignored.
- With FPSEQ_RESULT_CHAIN_EN:
  - Stimulus: back in SHOW with result 40400000.
  - Response: op_a=40400000, state LOAD_B idx=3, led=8'h28.

Source files
------------

// File: rtl/fpadd_operand_sequencer.sv
// fpadd_operand_sequencer: front-panel controller for the FP adder.
// Collects two 32-bit operands a byte at a time from the switches.
// It then starts the adder, waits for its result under a watchdog, and shows
// the result byte by byte on the LEDs.
// Optional feature macro: FPSEQ_RESULT_CHAIN_EN. When it is defined, back in SHOW
// copies the result into op_a and resumes at LOAD_B (accumulate chain).
module fpadd_operand_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_enter,
  input  logic        btn_back,
  input  logic [7:0]  sw,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        add_start,
  input  logic        add_done,
  input  logic [31:0] add_result,
  output logic [7:0]  led,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_SHOW   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  op_a_q;
  logic [WORD_W-1:0]  op_b_q;
  logic [WORD_W-1:0]  result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               enter;
  logic               back;
  logic [3:0]         idx_oh;

  // Both buttons in the same cycle cancel each other out.
  assign enter = btn_enter & ~btn_back;
  assign back  = btn_back & ~btn_enter;
  assign cnt_d = cnt_q + CNT_W'(1);

  // Sequencer state, byte index, operand/result registers and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD_A;
      idx_q    <= 2'd3;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (enter) begin
            op_a_q[{idx_q, 3'b000} +: 8] <= sw;
            if (idx_q == 2'd0) begin
              state_q <= S_LOAD_B;
              idx_q   <= 2'd3;
            end else begin
              idx_q <= idx_q - 2'd1;
            end
          end else if (back && (idx_q != 2'd3)) begin
            idx_q <= idx_q + 2'd1;
          end
        end
        S_LOAD_B: begin
          if (enter) begin
            op_b_q[{idx_q, 3'b000} +: 8] <= sw;
            if (idx_q == 2'd0) begin
              state_q <= S_START;
            end else begin
              idx_q <= idx_q - 2'd1;
            end
          end else if (back) begin
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
            end else begin
              state_q <= S_LOAD_A;
              idx_q   <= 2'd0;
            end
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle takes priority over the fault.
          if (add_done) begin
            result_q <= add_result;
            state_q  <= S_SHOW;
            idx_q    <= 2'd3;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
              state_q <= S_ERR;
            end
          end
        end
        S_SHOW: begin
          if (enter) begin
            idx_q <= idx_q - 2'd1;
          end else if (back) begin
`ifdef FPSEQ_RESULT_CHAIN_EN
            op_a_q  <= result_q;
            state_q <= S_LOAD_B;
`else
            state_q <= S_LOAD_A;
`endif
            idx_q <= 2'd3;
          end
        end
        S_ERR: begin
          if (enter || back) begin
            state_q <= S_LOAD_A;
            idx_q   <= 2'd3;
          end
        end
        default: begin
          state_q <= S_LOAD_A;
          idx_q   <= 2'd3;
        end
      endcase
    end
  end

  // Panel outputs decoded purely from registered state.
  always_comb begin
    idx_oh    = 4'b0001 << idx_q;
    led       = 8'h00;
    add_start = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_LOAD_A: led = {4'h1, idx_oh};
      S_LOAD_B: led = {4'h2, idx_oh};
      S_START: begin
        led       = 8'h40;
        add_start = 1'b1;
      end
      S_WAIT: begin
        led  = 8'h40;
        busy = 1'b1;
      end
      S_SHOW:  led = result_q[{idx_q, 3'b000} +: 8];
      S_ERR: begin
        led = 8'hEE;
        err = 1'b1;
      end
      default: led = 8'h00;
    endcase
  end

  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule

// File: tb/tb_fpadd_operand_sequencer.sv
// Bench for fpadd_operand_sequencer: directed panel scenarios plus randomized
// transactions; operand/result expectations flow through scoreboard queues.
module tb_fpadd_operand_sequencer;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_enter;
  logic        btn_back;
  logic [7:0]  sw;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        add_start;
  logic        add_done;
  logic [31:0] add_result;
  logic [7:0]  led;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] b; } start_t;
  typedef struct packed { logic [1:0] kind; logic [31:0] res; } done_t;  // kind 0 result, 1 fault, 2 reset

  start_t start_q[$];
  done_t  done_q[$];

  logic [31:0] m_a;
  logic [31:0] m_b;
  bit          in_b;

  always #5 clk = ~clk;

  fpadd_operand_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_back(btn_back), .sw(sw),
    .op_a(op_a), .op_b(op_b), .add_start(add_start), .add_done(add_done),
    .add_result(add_result), .led(led), .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] load_led(input logic [3:0] ph, input int pos);
    logic [3:0] oh;
    oh = 4'b0001 << pos;
    return {ph, oh};
  endfunction

  // One clock: drive inputs, let the edge sample them, return 1 ns after it.
  task automatic cyc(input logic en, input logic bk, input logic [7:0] s,
                     input logic dn, input logic [31:0] r);
    btn_enter = en; btn_back = bk; sw = s; add_done = dn; add_result = r;
    @(posedge clk); #1;
    btn_enter = 1'b0; btn_back = 1'b0; add_done = 1'b0; add_result = $urandom;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'($urandom), 1'b0, $urandom);
  endtask

  task automatic load_a(input logic [31:0] v, input bit fix);
    logic [7:0] g;
    for (int p = 3; p >= 0; p--) begin
      if ($urandom_range(0, 5) == 0) begin
        cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 0);
        chk("a_both_led", 32'(led), 32'(load_led(4'h1, p)));
        chk("a_both_op", op_a, m_a);
      end
      if ($urandom_range(0, 5) == 0) begin
        cyc(1'b0, 1'b0, 8'($urandom), 1'b1, $urandom);
        chk("a_stray_done_led", 32'(led), 32'(load_led(4'h1, p)));
      end
      if (fix && $urandom_range(0, 2) == 0) begin
        g = 8'($urandom);
        cyc(1'b1, 1'b0, g, 1'b0, 0);
        m_a[8*p +: 8] = g;
        chk("a_slip_led", 32'(led), 32'(p == 0 ? load_led(4'h2, 3) : load_led(4'h1, p - 1)));
        cyc(1'b0, 1'b1, 8'($urandom), 1'b0, 0);
        chk("a_back_led", 32'(led), 32'(load_led(4'h1, p)));
        chk("a_slip_op", op_a, m_a);
      end
      cyc(1'b1, 1'b0, v[8*p +: 8], 1'b0, 0);
      m_a[8*p +: 8] = v[8*p +: 8];
      chk("a_op", op_a, m_a);
      chk("a_led", 32'(led), 32'(p == 0 ? load_led(4'h2, 3) : load_led(4'h1, p - 1)));
    end
  endtask

  task automatic load_b(input logic [31:0] v, input bit fix);
    logic [7:0] g;
    start_t s;
    for (int p = 3; p >= 0; p--) begin
      if ($urandom_range(0, 5) == 0) begin
        cyc(1'b0, 1'b0, 8'($urandom), 1'b1, $urandom);
        chk("b_stray_done_led", 32'(led), 32'(load_led(4'h2, p)));
      end
      if (fix && p > 0 && $urandom_range(0, 2) == 0) begin
        g = 8'($urandom);
        cyc(1'b1, 1'b0, g, 1'b0, 0);
        m_b[8*p +: 8] = g;
        chk("b_slip_led", 32'(led), 32'(load_led(4'h2, p - 1)));
        cyc(1'b0, 1'b1, 8'($urandom), 1'b0, 0);
        chk("b_back_led", 32'(led), 32'(load_led(4'h2, p)));
      end
      if (p == 0) begin
        s.a = m_a;
        s.b = {m_b[31:8], v[7:0]};
        start_q.push_back(s);
      end
      cyc(1'b1, 1'b0, v[8*p +: 8], 1'b0, 0);
      m_b[8*p +: 8] = v[8*p +: 8];
      chk("b_op", op_b, m_b);
      if (p > 0) chk("b_led", 32'(led), 32'(load_led(4'h2, p - 1)));
    end
    chk("start_led", 32'(led), 32'h40);
    chk("start_pulse", 32'(add_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd0);
  endtask

  // k in 1..TO: done sampled k edges after entering WAIT; k==0: adder never answers.
  task automatic wait_done(input logic [31:0] res, input int k);
    done_t d;
    int n;
    d.kind = (k > 0) ? 2'd0 : 2'd1;
    d.res  = res;
    done_q.push_back(d);
    n = (k > 0) ? k : int'(TO);
    for (int c = 1; c <= n; c++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, $urandom);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_err", 32'(err), 32'd0);
      chk("wait_pulse", 32'(add_start), 32'd0);
      chk("wait_op_a", op_a, m_a);
      chk("wait_op_b", op_b, m_b);
    end
    if (k > 0) begin
      cyc(1'b0, 1'b0, 8'($urandom), 1'b1, res);
      chk("show_first", 32'(led), 32'(res[31:24]));
    end else begin
      idle();
      chk("to_err", 32'(err), 32'd1);
      chk("to_led", 32'(led), 32'hEE);
    end
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  task automatic show_exit(input logic [31:0] res);
    int bi;
    for (int n = 1; n <= 4; n++) begin
      cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 0);
      bi = (3 - n) & 3;
      chk("show_led", 32'(led), 32'(res[8*bi +: 8]));
    end
    cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 0);
    chk("show_both", 32'(led), 32'(res[31:24]));
    cyc(1'b0, 1'b1, 8'($urandom), 1'b0, 0);
`ifdef FPSEQ_RESULT_CHAIN_EN
    m_a  = res;
    in_b = 1'b1;
    chk("chain_led", 32'(led), 32'h28);
`else
    in_b = 1'b0;
    chk("exit_led", 32'(led), 32'h18);
`endif
    chk("exit_op_a", op_a, m_a);
    chk("exit_op_b", op_b, m_b);
  endtask

  task automatic err_exit();
    if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 0);
    else cyc(1'b0, 1'b1, 8'($urandom), 1'b0, 0);
    in_b = 1'b0;
    chk("err_exit_led", 32'(led), 32'h18);
    chk("err_exit_err", 32'(err), 32'd0);
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int k, input bit fix);
    if (!in_b) load_a(a, fix);
    load_b(b, fix);
    wait_done(res, k);
    if (k > 0) show_exit(res);
    else err_exit();
  endtask

  // Monitor: checks each start pulse and each WAIT exit against the scoreboard.
  initial begin
    bit prev_busy;
    bit prev_start;
    start_t s;
    done_t d;
    prev_busy = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (add_start === 1'b1) begin
        chk("mon_start_width", 32'(prev_start), 32'd0);
        chk("mon_start_expected", 32'(start_q.size() > 0), 32'd1);
        if (start_q.size() > 0) begin
          s = start_q.pop_front();
          chk("mon_op_a", op_a, s.a);
          chk("mon_op_b", op_b, s.b);
        end
      end
      if (prev_busy && (busy === 1'b0)) begin
        chk("mon_done_expected", 32'(done_q.size() > 0), 32'd1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          case (d.kind)
            2'd0: begin
              chk("mon_result_led", 32'(led), 32'(d.res[31:24]));
              chk("mon_result_err", 32'(err), 32'd0);
            end
            2'd1: begin
              chk("mon_fault_led", 32'(led), 32'hEE);
              chk("mon_fault_err", 32'(err), 32'd1);
            end
            default: begin
              chk("mon_reset_led", 32'(led), 32'h18);
              chk("mon_reset_err", 32'(err), 32'd0);
            end
          endcase
        end
      end
      prev_busy  = (busy === 1'b1);
      prev_start = (add_start === 1'b1);
    end
  end

  initial begin
    rst = 1'b1; btn_enter = 1'b0; btn_back = 1'b0; sw = 8'h00;
    add_done = 1'b0; add_result = 32'h0;
    m_a = 32'h0; m_b = 32'h0; in_b = 1'b0;
    idle(); idle();
    rst = 1'b0;
    chk("rst_led", 32'(led), 32'h18);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(add_start), 32'd0);

    // Simultaneous buttons, back-step correction, back from LOAD_B idx 3.
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 0);
    chk("both_led", 32'(led), 32'h18);
    chk("both_op_a", op_a, 32'h0);
    cyc(1'b1, 1'b0, 8'hAA, 1'b0, 0);
    chk("aa_op_a", op_a, 32'hAA000000);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 0);
    chk("back_led", 32'(led), 32'h18);
    cyc(1'b1, 1'b0, 8'h3F, 1'b0, 0);
    chk("fix_op_a", op_a, 32'h3F000000);
    chk("fix_led", 32'(led), 32'h14);
    cyc(1'b1, 1'b0, 8'h80, 1'b0, 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0);
    chk("a1_led", 32'(led), 32'h11);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0);
    chk("to_b_led", 32'(led), 32'h28);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 0);
    chk("b_back_a_led", 32'(led), 32'h11);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 0);
    chk("re_b_led", 32'(led), 32'h28);
    m_a = 32'h3F800000;
    chk("basic_op_a", op_a, m_a);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF);
    chk("b_done_ignored_led", 32'(led), 32'h28);

    // Basic add: 1.0 + 2.0 = 3.0, done on the third WAIT edge.
    load_b(32'h40000000, 1'b0);
    wait_done(32'h40400000, 3);
    show_exit(32'h40400000);

    // Watchdog fault, then done on the timeout edge (done wins).
    run_txn($urandom, $urandom, 32'h0, 0, 1'b0);
    run_txn($urandom, $urandom, $urandom, int'(TO), 1'b0);

    // Reset while waiting; a late done must be ignored.
    if (!in_b) load_a($urandom, 1'b1);
    load_b($urandom, 1'b1);
    idle(); idle();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    begin
      done_t d;
      d.kind = 2'd2;
      d.res  = 32'h0;
      done_q.push_back(d);
    end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    m_a = 32'h0; m_b = 32'h0; in_b = 1'b0;
    chk("wrst_led", 32'(led), 32'h18);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_op_a", op_a, 32'h0);
    chk("wrst_op_b", op_b, 32'h0);
    chk("wrst_start", 32'(add_start), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, $urandom);
    chk("late_done_led", 32'(led), 32'h18);
    chk("late_done_busy", 32'(busy), 32'd0);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      run_txn($urandom, $urandom, $urandom, int'($urandom_range(0, TO)), 1'b1);
    end

    idle(); idle();
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
